final_permutation_stage: RTL and testbench

Output stage of the DES datapath and the inverse of the initial-permutation block. It accepts the round-16 halves (L16, R16) over a valid/ready handshake, performs the final half-swap, applies the inverse initial permutation (IP⁻¹), and buffers results in a 2-entry FIFO. Results leave on a valid/ready output port toward the stream packer. A wrapping counter reports how many blocks have been delivered.

---
 rtl/final_permutation_stage.sv | 94 +++++++++
 tb/tb_final_permutation_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/final_permutation_stage.sv
// DES output stage: final half-swap, inverse initial permutation and a
// 2-entry output FIFO with a wrapping delivered-block counter.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   clear               synchronous FIFO flush (blk_count kept)
//   in_valid/in_ready   input handshake for l_in (L16) / r_in (R16)
//   out_valid/out_ready output handshake for out_data (MSB = DES bit 1)
//   blk_count           blocks delivered, wraps modulo 2^CNT_W
module final_permutation_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      l_in,
    input  logic [31:0]      r_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [CNT_W-1:0] blk_count
);

    // Column base of IP^-1: {40,8,48,16,56,24,64,32}.
    // Even columns step 40,48,56,64; odd columns step 8,16,24,32.
    function automatic int t_col(input int c);
        return (c % 2 == 0) ? 40 + 4 * c : 4 + 4 * c;
    endfunction

    logic [63:0] pre;
    logic [63:0] perm;

    // The swap puts R16 in the DES bit 1..32 positions.
    assign pre = {r_in, l_in};

    // DES bit k lives at index 64-k on both sides.
    for (genvar r = 0; r < 8; r++) begin : g_row
        for (genvar c = 0; c < 8; c++) begin : g_col
            localparam int K = t_col(c) - r;
            assign perm[63-(8*r+c)] = pre[64-K];
        end
    end

    logic [63:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    assign in_ready  = (int'(count) < DEPTH);
    assign out_valid = (count != 2'd0);
    assign out_data  = out_valid ? mem[rd_ptr] : 64'h0;

    assign push = in_valid & in_ready & ~clear;
    assign pop  = out_valid & out_ready & ~clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            blk_count <= '0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                blk_count <= blk_count + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= perm;
        end
    end

endmodule

// File: tb/tb_final_permutation_stage.sv
// Scoreboard bench for final_permutation_stage: directed vectors,
// walking-one sweep, backpressure, flush and async reset.
module tb_final_permutation_stage;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] l_in;
    logic [31:0] r_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [15:0] blk_count;

    final_permutation_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .l_in      (l_in),
        .r_in      (r_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .blk_count (blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard DES FP table: entry p-1 names the input bit for output p.
    localparam int FP [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    function automatic logic [63:0] fp_model(input logic [63:0] p);
        logic [63:0] o;
        o = '0;
        for (int q = 1; q <= 64; q++) begin
            o[64-q] = p[64-FP[q-1]];
        end
        return o;
    endfunction

    logic [63:0] exp_q [$];
    int          n_vec;
    int          n_fail;
    logic [15:0] exp_cnt;
    bit          sweep_on;
    logic [63:0] acc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each delivered word is checked against the queue head.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_out: got %h expected none",
                         out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e);
            end
            chk("blk_count", 64'(blk_count), 64'(exp_cnt));
            exp_cnt = exp_cnt + 16'd1;
            if (sweep_on) acc = acc | out_data;
        end
    end

    task automatic send(input logic [31:0] l, input logic [31:0] r,
                        input logic [63:0] e);
        int  w;
        bit  done;
        w    = 0;
        done = 0;
        in_valid = 1'b1;
        l_in     = l;
        r_in     = r;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end else if (++w > 20) begin
                n_vec++;
                n_fail++;
                $display("FAIL send_timeout: got in_ready 0 expected 1");
                in_valid = 1'b0;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 30) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d left expected 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [63:0] pw;
    logic [15:0] base;

    initial begin
        n_vec     = 0;
        n_fail    = 0;
        exp_cnt   = '0;
        sweep_on  = 0;
        acc       = '0;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        l_in      = '0;
        r_in      = '0;
        out_ready = 1'b0;

        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_blk_count", 64'(blk_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Bit mapping, case 1, with latency and counter check
        out_ready = 1'b1;
        send(32'h0100_0000, 32'h0, 64'h8000_0000_0000_0000);
        chk("latency_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        chk("cnt_after_1", 64'(blk_count), 64'd1);

        // Bit mapping, case 2 and the known DES vector
        send(32'h0, 32'h8000_0000, 64'h0000_0000_0000_0040);
        send(32'h4342_3234, 32'h0A4C_D995, 64'h85E8_1354_0F0A_B405);
        drain();

        // Walking one through {r_in, l_in}, back to back
        sweep_on = 1;
        acc      = '0;
        for (int i = 0; i < 64; i++) begin
            pw = 64'd1 << i;
            send(pw[31:0], pw[63:32], fp_model(pw));
        end
        drain();
        sweep_on = 0;
        chk("sweep_cover", acc, {64{1'b1}});

        // Backpressure: A, B buffered, C stalled
        out_ready = 1'b0;
        base = exp_cnt;
        send(32'h1111_2222, 32'h3333_4444,
             fp_model({32'h3333_4444, 32'h1111_2222}));
        send(32'hDEAD_BEEF, 32'h0123_4567,
             fp_model({32'h0123_4567, 32'hDEAD_BEEF}));
        in_valid = 1'b1;
        l_in     = 32'hA5A5_0F0F;
        r_in     = 32'hFFFF_0000;
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("stall_data", out_data,
            fp_model({32'h3333_4444, 32'h1111_2222}));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'hA5A5_0F0F, 32'hFFFF_0000,
             fp_model({32'hFFFF_0000, 32'hA5A5_0F0F}));
        drain();
        chk("bp_count", 64'(blk_count), 64'(base + 16'd3));

        // Flush with two entries buffered
        out_ready = 1'b0;
        send(32'h0000_0001, 32'h0, fp_model(64'h1));
        send(32'h0000_0002, 32'h0, fp_model(64'h2));
        base = exp_cnt;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("clr_out_valid", 64'(out_valid), 64'd0);
        chk("clr_in_ready", 64'(in_ready), 64'd1);
        chk("clr_blk_count", 64'(blk_count), 64'(base));

        // Async reset while a block is waiting
        @(posedge clk);
        #1;
        send(32'h7777_8888, 32'h9999_AAAA,
             fp_model({32'h9999_AAAA, 32'h7777_8888}));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_data", out_data, 64'h0);
        chk("arst_blk_count", 64'(blk_count), 64'd0);
        exp_q.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h4342_3234, 32'h0A4C_D995, 64'h85E8_1354_0F0A_B405);
        drain();
        chk("post_rst_count", 64'(blk_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_fail);
        $finish;
    end

endmodule
